// File: rtl/collision_scan.sv
// collision_scan: walks a synchronous-read tile table once per start pulse and
// reports down/up/right/left contact between a latched player box and every
// valid tile, together with the lowest tile index that hit each side.
module collision_scan #(
  parameter int XW      = 10,
  parameter int YW      = 9,
  parameter int N_TILES = 32,
  parameter int IDX_W   = (N_TILES > 1) ? $clog2(N_TILES) : 1,
  parameter int PW      = 23,
  parameter int PH      = 45,
  parameter int TW      = 25,
  parameter int TH      = 24,
  parameter int MARGIN  = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [XW-1:0]      x_p,
  input  logic [YW-1:0]      y_p,
  output logic [IDX_W-1:0]   tile_addr,
  input  logic [XW-1:0]      tile_x,
  input  logic [YW-1:0]      tile_y,
  input  logic               tile_valid,
  output logic               busy,
  output logic               done,
  output logic [3:0]         is_Collision,
  output logic [4*IDX_W-1:0] hit_idx
);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

  // Sums are carried one bit wider than the coordinates so that a player edge
  // past the right/bottom of the screen can never alias onto a small tile value.
  localparam int XE = XW + 1;
  localparam int YE = YW + 1;
  localparam logic [XE-1:0]    PW_X = XE'(PW);
  localparam logic [XE-1:0]    TW_X = XE'(TW);
  localparam logic [XE-1:0]    MG_X = XE'(MARGIN);
  localparam logic [YE-1:0]    PH_Y = YE'(PH);
  localparam logic [YE-1:0]    TH_Y = YE'(TH);
  localparam logic [YE-1:0]    MG_Y = YE'(MARGIN);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N_TILES - 1);

  state_t                  state, state_nxt;
  logic [XW-1:0]           px_q;
  logic [YW-1:0]           py_q;
  logic                    rd_pend;   // tile data on the inputs belongs to rd_idx
  logic [IDX_W-1:0]        rd_idx;
  logic [3:0]              acc_flag, flag_nxt;
  logic [3:0][IDX_W-1:0]   acc_idx, idx_nxt;

  logic [XE-1:0] px_e, xt_e;
  logic [YE-1:0] py_e, yt_e;
  logic          h_ov, v_ov;
  logic [3:0]    hit;

  assign px_e = {1'b0, px_q};
  assign xt_e = {1'b0, tile_x};
  assign py_e = {1'b0, py_q};
  assign yt_e = {1'b0, tile_y};

  assign h_ov = (px_e + MG_X < xt_e + TW_X) && (px_e + PW_X > xt_e + MG_X);
  assign v_ov = (py_e + MG_Y < yt_e + TH_Y) && (py_e + PH_Y > yt_e + MG_Y);

  // Per-side contact of the currently presented tile, gated by its validity.
  always_comb begin
    hit    = '0;
    hit[0] = h_ov && (py_e + PH_Y == yt_e);
    hit[1] = h_ov && (py_e == yt_e + TH_Y);
    hit[2] = v_ov && (px_e + PW_X == xt_e);
    hit[3] = v_ov && (px_e == xt_e + TW_X);
    if (!(rd_pend && tile_valid)) hit = '0;
  end

  // Merge the current tile into the accumulators; the first hit per side wins.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    flag_nxt = acc_flag;
    idx_nxt  = acc_idx;
    for (int s = 0; s < 4; s++) begin
      if (hit[s] && !acc_flag[s]) begin
        flag_nxt[s] = 1'b1;
        idx_nxt[s]  = rd_idx;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // FSM next-state and busy decode.
  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    case (state)
      IDLE:    if (start) state_nxt = SCAN;
      SCAN:    if (tile_addr == LAST) state_nxt = DRAIN;
      DRAIN:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: position latch, address counter, read pipeline, accumulators, results.
  always_ff @(posedge clk) begin
    if (rst) begin
      px_q         <= '0;
      py_q         <= '0;
      tile_addr    <= '0;
      rd_pend      <= 1'b0;
      rd_idx       <= '0;
      acc_flag     <= '0;
      acc_idx      <= '0;
      is_Collision <= '0;
      hit_idx      <= '0;
      done         <= 1'b0;
    end else begin
      done    <= 1'b0;
      rd_pend <= (state == SCAN);
      rd_idx  <= tile_addr;
      case (state)
        IDLE: begin
          if (start) begin
            px_q      <= x_p;
            py_q      <= y_p;
            tile_addr <= '0;
            acc_flag  <= '0;
            acc_idx   <= '0;
          end
        end
        SCAN: begin
          acc_flag <= flag_nxt;
          acc_idx  <= idx_nxt;
          if (tile_addr != LAST) tile_addr <= tile_addr + IDX_W'(1);
        end
        DRAIN: begin
          // The last tile is still on the inputs, so results take the merged view.
          acc_flag     <= flag_nxt;
          acc_idx      <= idx_nxt;
          is_Collision <= flag_nxt;
          hit_idx      <= idx_nxt;
          done         <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
